tristate_bus_arbiter: RTL
=========================

Name: tristate_bus_arbiter

Overview:
- Parametrised successor to the single-driver tri-state buffer: N channels share one WIDTH-bit tri-state bus.
- Registered round-robin arbiter grants the bus to one channel at a time, enforces a maximum hold time, and inserts a one-cycle high-Z turnaround between owners so drivers never overlap.
- Sits between local requesters and a shared inout bus; the bus is observable through the bus_rd read-back.

Parameters:
- WIDTH, 8, bus data width in bits (>=1).
- N, 4, number of requesting channels (>=2).
- MAX_HOLD, 4, maximum consecutive GRANT cycles per tenure; 0 = unlimited.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-channel bus request, level-sensitive, held while the channel wants the bus.
- din  input  N*WIDTH  channel data; channel i occupies din[i*WIDTH +: WIDTH].
- bus  inout  WIDTH  shared tri-state bus; driven only by the granted channel, else 'z.
- bus_rd  output  WIDTH  continuous read-back of bus.
- gnt  output  N  one-hot grant, registered.
- owner  output  $clog2(N)  index of current grant holder; 0 when idle.
- busy  output  1  high while in GRANT.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, gnt=0, owner=0, busy=0, hold_cnt=0, rr_ptr=0; bus='z from the next edge on. Reset overrides everything, including mid-grant: the bus releases without a turnaround cycle.
- Output enable is the registered gnt. bus = din slice of owner when |gnt, else {WIDTH{1'bz}}. Data follows din combinationally while the grant is held.
- States:
  - IDLE: gnt=0. If |req at edge -> GRANT to arbitration winner, else stay.
  - GRANT: exactly one gnt bit high; hold_cnt increments each cycle starting at 1.
    - -> TURN when req[owner]=0 at the edge.
    - -> TURN when MAX_HOLD!=0 and hold_cnt==MAX_HOLD, even if req[owner] is still high.
  - TURN: exactly one cycle, gnt=0, bus='z. At the edge: if |req -> GRANT to winner, else -> IDLE.
- Arbitration: search req from index rr_ptr upward, wrapping at N-1->0; the first set bit wins. On each grant, rr_ptr <= (winner+1) mod N.
  - Requests dropped before the arbitration edge are not granted.
- Latency:
  - req rising in IDLE -> gnt/bus driven on the next edge (1 cycle).
  - Owner release -> 1 TURN cycle -> next owner driven on the following edge (back-to-back owners have exactly 1 'z cycle between them).
- hold_cnt: width $clog2(MAX_HOLD+1), minimum 1. Cleared in IDLE and TURN.
- Simultaneous events:
  - Owner drops req in the same cycle hold_cnt reaches MAX_HOLD: single transition to TURN.
  - A forced-release owner still requesting competes normally in TURN. It wins only if no other channel lies between rr_ptr and it.
- Invariants:
  - $onehot0(gnt) always.
  - gnt never changes directly from one nonzero value to another; a zero cycle always separates owners.
  - busy == |gnt.

Test Plan (WIDTH=8, N=4, MAX_HOLD=4):
- Reset with req=4'b1111 held -> gnt=0, bus=8'hzz, owner=0 during reset. First edge after rst falls -> gnt=4'b0001, bus_rd=din[7:0]=8'hA0.
- Single request: req=4'b0100, din ch2=8'h5C. Next edge -> gnt=4'b0100, owner=2, bus_rd=8'h5C. Drop req -> 1 cycle bus=8'hzz, then IDLE.
- Hold limit: req=4'b0010 held for 10 cycles -> gnt=4'b0010 for exactly 4 cycles, 1 'z cycle, then re-grant to ch1 (no other requesters). Repeats in a 4-on/1-off pattern.
- Round-robin: req=4'b1111 held -> grant order ch0,ch1,ch2,ch3,ch0, each 4 cycles with 1 'z cycle between. gnt never shows two bits set.
- Wrap-around: rr_ptr=3 (after a ch2 grant), req=4'b1001 -> ch3 granted first, then ch0.
- Reset mid-grant: ch1 owning with hold_cnt=2, rst pulsed 1 cycle -> the next edge gives gnt=0, bus=8'hzz, rr_ptr=0. The following arbitration with req=4'b0011 grants ch0.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for N channels sharing one tri-state bus.
// It limits how long a channel may hold the bus and leaves the bus high-Z for one cycle between owners.
module tristate_bus_arbiter #(
    parameter int WIDTH    = 8,
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*WIDTH-1:0]     din,
    inout  wire  [WIDTH-1:0]       bus,
    output logic [WIDTH-1:0]       bus_rd,
    output logic [N-1:0]           gnt,
    output logic [$clog2(N)-1:0]   owner,
    output logic                   busy
);
    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);

    // state  | meaning
    // IDLE   | no owner, bus high-Z, waiting for any request
    // GRANT  | one channel drives the bus, hold counter running
    // TURN   | single high-Z turnaround cycle between owners
    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_gnt, w_gnt_nxt;
    logic [IW-1:0]   r_owner, w_owner_nxt;
    logic [HW-1:0]   r_hold_cnt, w_hold_nxt;
    logic [IW-1:0]   r_rr_ptr, w_rr_nxt;

    logic            w_found;
    logic [IW-1:0]   w_winner;
    int              w_idx;
    logic            w_release;
    logic            w_drive;
    logic [WIDTH-1:0] w_data;

    // The rotating search starts at rr_ptr. The first set request bit wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % N;
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = IW'(w_idx);
            end
        end
    end

    assign w_release = !req[r_owner] ||
                       ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LIM));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_hold_nxt  = r_hold_cnt;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            IDLE, TURN: begin
                w_gnt_nxt   = '0;
                w_owner_nxt = '0;
                w_hold_nxt  = '0;
                w_state_nxt = IDLE;
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << w_winner;
                    w_owner_nxt = w_winner;
                    w_hold_nxt  = HW'(1);
                    w_rr_nxt    = IW'((int'(w_winner) + 1) % N);
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_nxt = TURN;
                    w_gnt_nxt   = '0;
                    w_owner_nxt = '0;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt  = r_hold_cnt + HW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_owner_nxt = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // Reset drops the grant at once, without a turnaround cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_hold_cnt <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_owner    <= w_owner_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rr_ptr   <= w_rr_nxt;
        end
    end

    assign w_drive = |r_gnt;
    assign w_data  = din[int'(r_owner)*WIDTH +: WIDTH];
    assign bus     = w_drive ? w_data : {WIDTH{1'bz}};
    assign bus_rd  = bus;
    assign gnt     = r_gnt;
    assign owner   = r_owner;
    assign busy    = (r_state == GRANT);

endmodule
